// File: rtl/svunit_check_aggregator.sv
// svunit_check_aggregator
//   Collects pass/fail strobes from NUM_CH checkers and brackets them into
//   tests delimited by start/stop.
//   Per test it keeps:
//     - saturating pass/fail counts
//     - the first failing channel
//     - an optional RUN-cycle timeout
//   Across tests it keeps suite totals (tests run, tests failed).
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start, stop     begin a test (IDLE/DONE), end a test (RUN)
//   chk_valid/pass  per-channel check strobe and result
//   running, done   state is RUN / DONE
//   pass_cnt        passing checks in the current/last test
//   fail_cnt        failing checks in the current/last test
//   first_fail_*    first failing channel of the test, and its valid flag
//   timed_out       last test ended by timeout
//   verdict_pass    done && no failures && no timeout
//   tests_run       completed tests since reset (saturating)
//   tests_failed    completed tests with a fail verdict (saturating)
module svunit_check_aggregator #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 0,
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [NUM_CH-1:0] chk_valid,
    input  logic [NUM_CH-1:0] chk_pass,
    output logic              running,
    output logic              done,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic              first_fail_vld,
    output logic [CH_W-1:0]   first_fail_ch,
    output logic              timed_out,
    output logic              verdict_pass,
    output logic [CNT_W-1:0]  tests_run,
    output logic [CNT_W-1:0]  tests_failed
);

    localparam int unsigned PC_W     = 6;
    localparam int unsigned TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic             ff_vld_q, ff_vld_d;
    logic [CH_W-1:0]  ff_ch_q, ff_ch_d;
    logic             timed_out_q, timed_out_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [CNT_W-1:0] tests_run_q, tests_run_d;
    logic [CNT_W-1:0] tests_failed_q, tests_failed_d;

    logic [PC_W-1:0]  pass_pc, fail_pc;
    logic             fail_any;
    logic [CH_W-1:0]  fail_low_ch;
    logic             tmo_hit;
    logic             enter_run, enter_done;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [PC_W-1:0]  b);
        logic [CNT_W+PC_W-1:0] s;
        s = {{PC_W{1'b0}}, a} + {{CNT_W{1'b0}}, b};
        if (s[CNT_W+PC_W-1:CNT_W] != '0) begin
            return '1;
        end
        return s[CNT_W-1:0];
    endfunction

    // Per-cycle popcounts and lowest-index failing channel.
    always_comb begin
        pass_pc     = '0;
        fail_pc     = '0;
        fail_any    = 1'b0;
        fail_low_ch = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            pass_pc = pass_pc + PC_W'(chk_valid[i] & chk_pass[i]);
            fail_pc = fail_pc + PC_W'(chk_valid[i] & ~chk_pass[i]);
            if (chk_valid[i] && !chk_pass[i] && !fail_any) begin
                fail_any    = 1'b1;
                fail_low_ch = CH_W'(i);
            end
        end
    end

    assign tmo_hit    = (TIMEOUT != 0) && (state_q == ST_RUN) &&
                        (tmo_cnt_q == TMO_W'(TMO_LAST));
    assign enter_run  = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start;
    assign enter_done = (state_q == ST_RUN) && (stop || tmo_hit);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (stop || tmo_hit) state_d = ST_DONE;
            ST_DONE: if (start) state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        running      = (state_q == ST_RUN);
        done         = (state_q == ST_DONE);
        verdict_pass = (state_q == ST_DONE) && (fail_cnt_q == '0) && !timed_out_q;
    end

    // Datapath next values
    always_comb begin
        pass_cnt_d     = pass_cnt_q;
        fail_cnt_d     = fail_cnt_q;
        ff_vld_d       = ff_vld_q;
        ff_ch_d        = ff_ch_q;
        timed_out_d    = timed_out_q;
        tmo_cnt_d      = tmo_cnt_q;
        tests_run_d    = tests_run_q;
        tests_failed_d = tests_failed_q;
        if (enter_run) begin
            pass_cnt_d  = '0;
            fail_cnt_d  = '0;
            ff_vld_d    = 1'b0;
            ff_ch_d     = '0;
            timed_out_d = 1'b0;
            tmo_cnt_d   = '0;
        end else if (state_q == ST_RUN) begin
            pass_cnt_d = sat_add(pass_cnt_q, pass_pc);
            fail_cnt_d = sat_add(fail_cnt_q, fail_pc);
            if (!ff_vld_q && fail_any) begin
                ff_vld_d = 1'b1;
                ff_ch_d  = fail_low_ch;
            end
            tmo_cnt_d = tmo_cnt_q + 1'b1;
            if (enter_done) begin
                // stop takes priority over a coincident timeout
                timed_out_d = !stop;
                tests_run_d = sat_add(tests_run_q, PC_W'(1));
                // verdict uses the updated count, so last-cycle failures matter
                if ((fail_cnt_d != '0) || timed_out_d) begin
                    tests_failed_d = sat_add(tests_failed_q, PC_W'(1));
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pass_cnt_q     <= '0;
            fail_cnt_q     <= '0;
            ff_vld_q       <= 1'b0;
            ff_ch_q        <= '0;
            timed_out_q    <= 1'b0;
            tmo_cnt_q      <= '0;
            tests_run_q    <= '0;
            tests_failed_q <= '0;
        end else begin
            pass_cnt_q     <= pass_cnt_d;
            fail_cnt_q     <= fail_cnt_d;
            ff_vld_q       <= ff_vld_d;
            ff_ch_q        <= ff_ch_d;
            timed_out_q    <= timed_out_d;
            tmo_cnt_q      <= tmo_cnt_d;
            tests_run_q    <= tests_run_d;
            tests_failed_q <= tests_failed_d;
        end
    end

    assign pass_cnt       = pass_cnt_q;
    assign fail_cnt       = fail_cnt_q;
    assign first_fail_vld = ff_vld_q;
    assign first_fail_ch  = ff_ch_q;
    assign timed_out      = timed_out_q;
    assign tests_run      = tests_run_q;
    assign tests_failed   = tests_failed_q;

endmodule

// File: tb/tb_svunit_check_aggregator.sv
// Directed bench for svunit_check_aggregator.
// Three instances share the stimulus:
//   u0: default parameters
//   u1: TIMEOUT=5
//   u2: CNT_W=4
module tb_svunit_check_aggregator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] vld = '0;
    logic [3:0] pss = '0;

    int n_checks = 0;
    int n_errors = 0;

    logic        run0, done0, ffv0, to0, vp0;
    logic [1:0]  ffc0;
    logic [15:0] pc0, fc0, tr0, tf0;

    logic        run1, done1, ffv1, to1, vp1;
    logic [1:0]  ffc1;
    logic [15:0] pc1, fc1, tr1, tf1;

    logic        run2, done2, ffv2, to2, vp2;
    logic [1:0]  ffc2;
    logic [3:0]  pc2, fc2, tr2, tf2;

    always #5 clk = ~clk;

    svunit_check_aggregator u0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .chk_valid(vld), .chk_pass(pss),
        .running(run0), .done(done0), .pass_cnt(pc0), .fail_cnt(fc0),
        .first_fail_vld(ffv0), .first_fail_ch(ffc0), .timed_out(to0),
        .verdict_pass(vp0), .tests_run(tr0), .tests_failed(tf0)
    );

    svunit_check_aggregator #(.TIMEOUT(5)) u1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .chk_valid(vld), .chk_pass(pss),
        .running(run1), .done(done1), .pass_cnt(pc1), .fail_cnt(fc1),
        .first_fail_vld(ffv1), .first_fail_ch(ffc1), .timed_out(to1),
        .verdict_pass(vp1), .tests_run(tr1), .tests_failed(tf1)
    );

    svunit_check_aggregator #(.CNT_W(4)) u2 (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .chk_valid(vld), .chk_pass(pss),
        .running(run2), .done(done2), .pass_cnt(pc2), .fail_cnt(fc2),
        .first_fail_vld(ffv2), .first_fail_ch(ffc2), .timed_out(to2),
        .verdict_pass(vp2), .tests_run(tr2), .tests_failed(tf2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_run0",  32'(run0), 32'd0);
        check("rst_done0", 32'(done0), 32'd0);
        check("rst_pc0",   32'(pc0), 32'd0);
        check("rst_fc0",   32'(fc0), 32'd0);
        check("rst_ffv0",  32'(ffv0), 32'd0);
        check("rst_ffc0",  32'(ffc0), 32'd0);
        check("rst_to0",   32'(to0), 32'd0);
        check("rst_vp0",   32'(vp0), 32'd0);
        check("rst_tr0",   32'(tr0), 32'd0);
        check("rst_tf0",   32'(tf0), 32'd0);

        // All-pass test: 3 cycles x 4 channels
        start = 1'b1;
        tick();
        start = 1'b0;
        check("p1_run", 32'(run0), 32'd1);
        check("p1_pc_clr", 32'(pc0), 32'd0);
        vld = 4'b1111; pss = 4'b1111;
        repeat (3) tick();
        vld = '0; pss = '0;
        check("p1_pc12_run", 32'(pc0), 32'd12);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("p1_done", 32'(done0), 32'd1);
        check("p1_run0", 32'(run0), 32'd0);
        check("p1_pc", 32'(pc0), 32'd12);
        check("p1_fc", 32'(fc0), 32'd0);
        check("p1_vp", 32'(vp0), 32'd1);
        check("p1_tr", 32'(tr0), 32'd1);
        check("p1_tf", 32'(tf0), 32'd0);

        // Checks in DONE are ignored
        vld = 4'b1111; pss = 4'b0000;
        tick();
        vld = '0;
        check("done_ign_fc", 32'(fc0), 32'd0);
        check("done_ign_done", 32'(done0), 32'd1);

        // Multi-fail test, back-to-back restart from DONE
        start = 1'b1;
        tick();
        start = 1'b0;
        check("p2_run", 32'(run0), 32'd1);
        check("p2_done0", 32'(done0), 32'd0);
        check("p2_pc_clr", 32'(pc0), 32'd0);
        check("p2_vp_run", 32'(vp0), 32'd0);
        check("p2_tr_kept", 32'(tr0), 32'd1);
        vld = 4'b1111; pss = 4'b0101;
        tick();
        check("p2_fc2", 32'(fc0), 32'd2);
        check("p2_pc2", 32'(pc0), 32'd2);
        check("p2_ffv", 32'(ffv0), 32'd1);
        check("p2_ffc", 32'(ffc0), 32'd1);
        vld = 4'b0001; pss = 4'b0000;
        tick();
        check("p2_fc3", 32'(fc0), 32'd3);
        check("p2_ffc_hold", 32'(ffc0), 32'd1);
        // check presented with stop is counted
        vld = 4'b0010; pss = 4'b0010; stop = 1'b1;
        tick();
        vld = '0; pss = '0; stop = 1'b0;
        check("p2_done", 32'(done0), 32'd1);
        check("p2_pc", 32'(pc0), 32'd3);
        check("p2_fc", 32'(fc0), 32'd3);
        check("p2_ffc_done", 32'(ffc0), 32'd1);
        check("p2_vp", 32'(vp0), 32'd0);
        check("p2_tr", 32'(tr0), 32'd2);
        check("p2_tf", 32'(tf0), 32'd1);

        // start+stop together in DONE: start wins; start in RUN ignored
        start = 1'b1; stop = 1'b1;
        tick();
        stop = 1'b0;
        check("p3_run", 32'(run0), 32'd1);
        check("p3_done0", 32'(done0), 32'd0);
        vld = 4'b0001; pss = 4'b0001;
        tick();
        start = 1'b0;
        check("p3_start_ign", 32'(pc0), 32'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0; vld = '0; pss = '0;
        check("p3_done", 32'(done0), 32'd1);
        check("p3_pc", 32'(pc0), 32'd2);
        check("p3_vp", 32'(vp0), 32'd1);
        check("p3_tr", 32'(tr0), 32'd3);
        check("p3_tf", 32'(tf0), 32'd1);

        // Reset mid-test
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        vld = 4'b0111; pss = 4'b0111;
        tick();
        vld = 4'b1111; pss = 4'b1111;
        tick();
        check("p4_pc7", 32'(pc0), 32'd7);
        vld = '0; pss = '0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("p4_run", 32'(run0), 32'd0);
        check("p4_done", 32'(done0), 32'd0);
        check("p4_pc", 32'(pc0), 32'd0);
        check("p4_tr", 32'(tr0), 32'd0);
        check("p4_tf", 32'(tf0), 32'd0);
        check("p4_tr1", 32'(tr1), 32'd0);

        // Timeout on u1: done after the 5th RUN cycle
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            check("tmo_run", 32'(run1), 32'd1);
            check("tmo_nodone", 32'(done1), 32'd0);
            tick();
        end
        check("tmo_run5", 32'(run1), 32'd1);
        vld = 4'b0001; pss = 4'b0001;
        tick();
        vld = '0; pss = '0;
        check("tmo_done", 32'(done1), 32'd1);
        check("tmo_to", 32'(to1), 32'd1);
        check("tmo_vp", 32'(vp1), 32'd0);
        check("tmo_pc", 32'(pc1), 32'd1);
        check("tmo_tr", 32'(tr1), 32'd1);
        check("tmo_tf", 32'(tf1), 32'd1);
        repeat (8) tick();
        check("tmo0_run", 32'(run0), 32'd1);
        check("tmo1_hold", 32'(done1), 32'd1);

        // stop in the timeout cycle wins
        start = 1'b1;
        tick();
        start = 1'b0;
        check("tst_to_clr", 32'(to1), 32'd0);
        check("tst_run", 32'(run1), 32'd1);
        repeat (4) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("tst_done", 32'(done1), 32'd1);
        check("tst_to", 32'(to1), 32'd0);
        check("tst_vp", 32'(vp1), 32'd1);
        check("tst_tr", 32'(tr1), 32'd2);
        check("tst_tf", 32'(tf1), 32'd1);
        check("tst_done0", 32'(done0), 32'd1);
        check("tst_to0", 32'(to0), 32'd0);

        // Saturation on u2 (CNT_W=4)
        start = 1'b1;
        tick();
        start = 1'b0;
        vld = 4'b0001; pss = 4'b0001;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) check("sat_pc14", 32'(pc2), 32'd14);
            if (i == 15) check("sat_pc15", 32'(pc2), 32'd15);
        end
        check("sat_pc_hold", 32'(pc2), 32'd15);
        check("sat_pc0_wide", 32'(pc0), 32'd20);
        vld = '0; pss = '0; stop = 1'b1;
        tick();
        stop = 1'b0;
        check("sat_done", 32'(done2), 32'd1);
        check("sat_pc_done", 32'(pc2), 32'd15);
        check("sat_vp", 32'(vp2), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("sat_clr", 32'(pc2), 32'd0);
        vld = 4'b0001; pss = 4'b0000;
        repeat (18) tick();
        vld = '0;
        check("sat_fc", 32'(fc2), 32'd15);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("sat_fc_done", 32'(fc2), 32'd15);
        check("sat_vp_fail", 32'(vp2), 32'd0);
        check("sat_tr", 32'(tr2), 32'd3);
        check("sat_tf", 32'(tf2), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
